// File: rtl/axi_rob_pkg.sv
// axi_rob_pkg: shared types for the AXI read reorder buffer
package axi_rob_pkg;
  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } rresp_t;
endpackage

// File: rtl/rob_slot_table.sv
// rob_slot_table: per-slot alloc/done/id/data/resp storage with allocate, capture and retire ports
module rob_slot_table
  import axi_rob_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_i,
  input  logic [TAG_WIDTH-1:0]  alloc_idx_i,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  input  logic                  wr_i,
  input  logic [TAG_WIDTH-1:0]  wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [1:0]            wr_resp_i,
  input  logic [TAG_WIDTH-1:0]  rd_idx_i,
  input  logic                  retire_i,
  output logic                  rd_done_o,
  output logic [ID_WIDTH-1:0]   rd_id_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [1:0]            rd_resp_o,
  output logic                  err_o
);
  logic [DEPTH-1:0]      alloc_q, alloc_d, done_q, done_d;
  logic [ID_WIDTH-1:0]   id_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  rresp_t                resp_q [DEPTH];
  rresp_t                resp_d [DEPTH];
  logic                  wr_ok;
  // a beat is only accepted into an allocated, still-empty slot
  always_comb begin
    wr_ok   = wr_i & alloc_q[wr_idx_i] & ~done_q[wr_idx_i];
    err_o   = wr_i & ~wr_ok;
    alloc_d = alloc_q;
    done_d  = done_q;
    id_d    = id_q;
    data_d  = data_q;
    resp_d  = resp_q;
    if (retire_i) begin
      alloc_d[rd_idx_i] = 1'b0;
      done_d[rd_idx_i]  = 1'b0;
    end
    if (alloc_i) begin
      alloc_d[alloc_idx_i] = 1'b1;
      done_d[alloc_idx_i]  = 1'b0;
      id_d[alloc_idx_i]    = alloc_id_i;
    end
    if (wr_ok) begin
      done_d[wr_idx_i] = 1'b1;
      data_d[wr_idx_i] = wr_data_i;
      resp_d[wr_idx_i] = rresp_t'(wr_resp_i);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    id_q   <= id_d;
    data_q <= data_d;
    resp_q <= resp_d;
  end
  assign rd_done_o = done_q[rd_idx_i];
  assign rd_id_o   = id_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];
  assign rd_resp_o = resp_q[rd_idx_i];
endmodule

// File: rtl/axi_read_reorder_buffer.sv
// axi_read_reorder_buffer: tags ARs with slot indices and returns out-of-order R beats in AR order
module axi_read_reorder_buffer
  import axi_rob_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16,
  parameter int TAG_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [TAG_WIDTH-1:0]  m_arid_o,
  output logic                  m_arvalid_o,
  input  logic                  m_arready_i,
  input  logic [DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]            m_rresp_i,
  input  logic [TAG_WIDTH-1:0]  m_rid_i,
  input  logic                  m_rvalid_i,
  output logic                  m_rready_o,
  output logic [TAG_WIDTH:0]    count_o,
  output logic                  err_o
);
  logic [TAG_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d, arid_q, arid_d;
  logic [TAG_WIDTH:0]   count_q, count_d;
  logic                 arvalid_q, arvalid_d, err_q, err_d;
  logic                 acc, ret, rd_done, err_pulse;
  // full blocks accept even when a retire frees a slot this cycle
  always_comb begin
    s_arready_o = (count_q != (TAG_WIDTH+1)'(DEPTH)) & (~arvalid_q | m_arready_i);
    acc         = s_arvalid_i & s_arready_o;
    s_rvalid_o  = (count_q != '0) & rd_done;
    ret         = s_rvalid_o & s_rready_i;
    wp_d        = acc ? wp_q + TAG_WIDTH'(1) : wp_q;
    rp_d        = ret ? rp_q + TAG_WIDTH'(1) : rp_q;
    count_d     = count_q + (TAG_WIDTH+1)'(acc) - (TAG_WIDTH+1)'(ret);
    arvalid_d   = acc | (arvalid_q & ~m_arready_i);
    arid_d      = acc ? wp_q : arid_q;
    err_d       = err_q | err_pulse;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      arvalid_q <= arvalid_d;
      arid_q    <= arid_d;
      err_q     <= err_d;
    end
  end
  rob_slot_table #(
    .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) u_slots (
    .clk(clk), .rst(rst),
    .alloc_i(acc), .alloc_idx_i(wp_q), .alloc_id_i(s_arid_i),
    .wr_i(m_rvalid_i), .wr_idx_i(m_rid_i), .wr_data_i(m_rdata_i), .wr_resp_i(m_rresp_i),
    .rd_idx_i(rp_q), .retire_i(ret),
    .rd_done_o(rd_done), .rd_id_o(s_rid_o), .rd_data_o(s_rdata_o), .rd_resp_o(s_rresp_o),
    .err_o(err_pulse)
  );
  assign m_arvalid_o = arvalid_q;
  assign m_arid_o    = arid_q;
  assign m_rready_o  = 1'b1;
  assign count_o     = count_q;
  assign err_o       = err_q;
endmodule

// File: doc/axi_read_reorder_buffer.md
# axi_read_reorder_buffer

Parametrised read-channel reorder buffer placed between an in-order AXI-style read master and an out-of-order read slave. Every accepted AR is allocated a slot and forwarded downstream with the slot index as its tag. Out-of-order R beats are written into their slot, and responses are returned upstream strictly in AR acceptance order, carrying the original ID. Unlike the previous generation, it tolerates repeated IDs in flight, carries RRESP, is sized by parameters, and flags protocol violations.

## Interface

Parameters:
- DATA_WIDTH, 8, R data width
- ID_WIDTH, 4, upstream transaction ID width
- DEPTH, 16, maximum outstanding reads; power of two, at least 2
- TAG_WIDTH, $clog2(DEPTH), derived, not overridden; downstream tag width

Ports:
- clk  in  1  sole clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- s_arid_i  in  ID_WIDTH  upstream AR ID
- s_arvalid_i  in  1  upstream AR valid
- s_arready_o  out  1  upstream AR ready
- s_rdata_o  out  DATA_WIDTH  upstream R data
- s_rresp_o  out  2  upstream R response
- s_rid_o  out  ID_WIDTH  upstream R ID, equal to the original AR ID
- s_rvalid_o  out  1  upstream R valid
- s_rready_i  in  1  upstream R ready
- m_arid_o  out  TAG_WIDTH  downstream AR tag (slot index)
- m_arvalid_o  out  1  downstream AR valid
- m_arready_i  in  1  downstream AR ready
- m_rdata_i  in  DATA_WIDTH  downstream R data
- m_rresp_i  in  2  downstream R response
- m_rid_i  in  TAG_WIDTH  downstream R tag
- m_rvalid_i  in  1  downstream R valid
- m_rready_o  out  1  downstream R ready; tied to 1
- count_o  out  TAG_WIDTH+1  allocated slot count
- err_o  out  1  sticky protocol-error flag

## Operation

- Each slot holds alloc, done, id, data and resp. Slots form a circular queue with alloc pointer wp, retire pointer rp and count.
- **AR accept:** occurs when s_arvalid_i & s_arready_o.
  - s_arready_o = (count != DEPTH) & (~m_arvalid_o | m_arready_i).
  - On accept: slot[wp].alloc=1, done=0, id=s_arid_i; m_arid_o<=wp; m_arvalid_o<=1; wp++ (wraps modulo DEPTH).
- **AR output register:** a single-entry register. m_arvalid_o and m_arid_o are held stable until m_arready_i. m_arvalid_o clears on handshake unless a new accept happens in the same cycle.
- **R capture:** m_rready_o is constantly 1; space is reserved at allocation.
  - On m_rvalid_i with slot[m_rid_i].alloc=1 and done=0: store data and resp, set done=1.
  - If that slot has alloc=0 or done=1: drop the beat, set err_o=1, and leave slot state unchanged.
- **Upstream R:**
  - s_rvalid_o = (count != 0) & slot[rp].done.
  - s_rdata_o, s_rresp_o and s_rid_o come from slot[rp].
  - On s_rvalid_o & s_rready_i: clear alloc and done of slot[rp]; rp++ (wraps).
  - Outputs stay stable while s_rvalid_o=1 and s_rready_i=0.
- **count:** +1 on accept, −1 on retire, unchanged when both occur.
- **err_o:** sticky; cleared only by rst.
- **Data width:** data and resp are passed through unmodified. No arithmetic is performed on payload.

## Timing

- **Reset values:** m_arvalid_o=0, s_rvalid_o=0, count_o=0, err_o=0, wp=rp=0, all alloc/done=0; m_rready_o=1. s_arready_o=1 in the first cycle after reset release.
- **AR latency:** accept in cycle N gives m_arvalid_o=1 in N+1.
  - Back-to-back throughput is 1/cycle while m_arready_i=1.
  - Stalled downstream: the register holds one entry and s_arready_o drops.
- **R latency:** an m_r beat into slot rp in cycle N gives s_rvalid_o=1 in N+1. There is no same-cycle bypass.
- **Full:** count==DEPTH forces s_arready_o=0, even if a retire happens in the same cycle. The freed slot becomes usable in the next cycle.
- **Empty:** s_rvalid_o=0. Stray m_r beats set err_o.
- **Simultaneous events:**
  - Accept + retire in one cycle: both apply.
  - m_r write into slot rp + retire of rp in one cycle: impossible, because retire needs done=1 and a write to a done slot is an error.
- **Pointer wrap:** DEPTH−1 → 0 is transparent.
- **rst mid-operation:** all in-flight state is discarded next edge. Late downstream beats after reset set err_o.

## Structure

- Package axi_rob_pkg: rresp_t, a 2-bit enum with OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
- Sub-module rob_slot_table, parametrised by DEPTH/ID_WIDTH/DATA_WIDTH:
  - Holds the slot arrays.
  - Write port for allocation, write port for R capture, read port at rp.
  - Retire clear.
  - Generates the error pulse.
- Top level holds the pointers, count, AR output register and handshake logic.

## Test plan

- Reset, then 3 ARs with IDs 5,5,5 and downstream responses for tags 2,0,1 with data A2,A0,A1 → upstream R order A0,A1,A2, all rid=5, err_o=0.
- Issue 16 ARs with m_arready_i=1 and no R traffic → count_o=16, s_arready_o=0. Retire one → s_arready_o=1 one cycle later. The 17th AR gets tag 0.
- m_arready_i=0 for 4 cycles after one accept → m_arvalid_o held with m_arid_o stable, s_arready_o=0. Release → handshake, then a second accept proceeds.
- s_rready_i=0 with head done → s_rvalid_o, data, resp and id stable for 5 cycles. Releasing s_rready_i retires exactly one entry.
- R beat with tag 7 while empty, then a duplicate beat to a done slot → err_o=1 and stays set. The queued output is unaffected.
- m_rresp_i=SLVERR on tag 0 → s_rresp_o=SLVERR delivered in order. Assert rst mid-stream → all outputs take their reset values next cycle.
